// File: rtl/rrp_otf_convert_if.sv
// Handshake bundle between the online adder output, the on-the-fly converter and the readback path.
// Widths track RADIX/NDIG so the converter and its neighbours always agree on the digit packing.
interface rrp_otf_convert_if #(
  parameter int RADIX = 4,
  parameter int NDIG  = 16
);
  localparam int K  = $clog2(RADIX);
  localparam int D  = K + 1;
  localparam int OW = K * NDIG + 1;

  logic [NDIG*D-1:0] in_digits;
  logic              in_valid;
  logic              in_ready;
  logic [OW-1:0]     out_value;
  logic              out_err;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_digits, in_valid, out_ready,
    input  in_ready, out_value, out_err, out_valid
  );

  modport slave (
    input  in_digits, in_valid, out_ready,
    output in_ready, out_value, out_err, out_valid
  );
endinterface

// File: rtl/rrp_otf_convert.sv
// MSD-first on-the-fly converter: redundant signed-digit vector to two's complement,
// one digit per cycle, keeping Q (exact prefix) and QM (Q-1) so no carry chain is needed.
module rrp_otf_convert #(
  parameter int RADIX = 4,
  parameter int NDIG  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  rrp_otf_convert_if.slave   io_bus
);
  localparam int K  = $clog2(RADIX);
  localparam int D  = K + 1;
  localparam int OW = K * NDIG + 1;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [D-1:0] ILLEGAL = {1'b1, {K{1'b0}}};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic [NDIG*D-1:0] r_vec;
  logic [CW-1:0]     r_cnt;
  logic [OW-1:0]     r_q;
  logic [OW-1:0]     r_qm;
  logic              r_err;
  logic [OW-1:0]     r_value;
  logic              r_oerr;
  logic              r_ovalid;

  logic [D-1:0]      w_d;
  logic [K-1:0]      w_dm1;
  logic              w_neg;
  logic              w_pos;
  logic              w_errn;
  logic [OW-1:0]     w_qsel;
  logic [OW-1:0]     w_qmsel;
  logic [OW-1:0]     w_qn;
  logic [OW-1:0]     w_qmn;

  // The appended K-bit field is the digit (or digit-1) modulo RADIX, which covers
  // both the d and RADIX+d cases as well as d-1 and RADIX-1+d.
  assign w_d     = r_vec[int'(r_cnt)*D +: D];
  assign w_dm1   = w_d[K-1:0] - K'(1);
  assign w_neg   = w_d[D-1];
  assign w_pos   = !w_neg && (w_d != '0);
  assign w_errn  = r_err || (w_d == ILLEGAL);
  assign w_qsel  = w_neg ? r_qm : r_q;
  assign w_qmsel = w_pos ? r_q : r_qm;
  assign w_qn    = (w_qsel << K) | OW'(w_d[K-1:0]);
  assign w_qmn   = (w_qmsel << K) | OW'(w_dm1);

  assign io_bus.in_ready  = (r_state == IDLE);
  assign io_bus.out_value = r_value;
  assign io_bus.out_err   = r_oerr;
  assign io_bus.out_valid = r_ovalid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_bus.in_valid)              w_next = CONV;
      CONV:    if (r_cnt == '0)                  w_next = DONE;
      DONE:    if (r_ovalid && io_bus.out_ready) w_next = IDLE;
      default:                                   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec    <= '0;
      r_cnt    <= '0;
      r_q      <= '0;
      r_qm     <= '1;
      r_err    <= 1'b0;
      r_value  <= '0;
      r_oerr   <= 1'b0;
      r_ovalid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.in_valid) begin
            r_vec <= io_bus.in_digits;
            r_cnt <= CW'(NDIG - 1);
            r_q   <= '0;
            r_qm  <= '1;
            r_err <= 1'b0;
          end
        end
        CONV: begin
          r_q   <= w_qn;
          r_qm  <= w_qmn;
          r_err <= w_errn;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            r_value  <= w_qn;
            r_oerr   <= w_errn;
            r_ovalid <= 1'b1;
          end
        end
        DONE: begin
          if (io_bus.out_ready) r_ovalid <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rrp_otf_convert.sv
// Directed bench for rrp_otf_convert: a RADIX=4/NDIG=4 and a RADIX=2/NDIG=8 instance
// driven with hand-computed vectors, including backpressure, back-to-back and mid-conversion reset.
module tb_rrp_otf_convert;
  logic clk;
  logic rst_n;
  int   nChecks;
  int   nFails;

  rrp_otf_convert_if #(.RADIX(4), .NDIG(4)) bus4 ();
  rrp_otf_convert_if #(.RADIX(2), .NDIG(8)) bus2 ();

  rrp_otf_convert #(.RADIX(4), .NDIG(4)) dut4 (.clk(clk), .rst_n(rst_n), .io_bus(bus4));
  rrp_otf_convert #(.RADIX(2), .NDIG(8)) dut2 (.clk(clk), .rst_n(rst_n), .io_bus(bus2));

  always #5 clk = ~clk;

  function automatic logic [11:0] pack4(input int m3, input int m2, input int m1, input int m0);
    return {3'(m3), 3'(m2), 3'(m1), 3'(m0)};
  endfunction

  function automatic logic [15:0] pack2(input int m7, input int m6, input int m5, input int m4,
                                        input int m3, input int m2, input int m1, input int m0);
    return {2'(m7), 2'(m6), 2'(m5), 2'(m4), 2'(m3), 2'(m2), 2'(m1), 2'(m0)};
  endfunction

  task automatic conv4(input logic [11:0] vec, input logic [8:0] expVal, input logic expErr,
                       input logic checkVal, input string name);
    int lat;
    @(negedge clk);
    bus4.in_digits = vec;
    bus4.in_valid  = 1'b1;
    nChecks++;
    if (bus4.in_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL %s_ready: got %b expected 1", name, bus4.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid  = 1'b0;
    bus4.in_digits = '1;
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    nChecks++;
    if (lat != 4) begin
      nFails++; $display("[TB] FAIL %s_latency: got %0d expected 4", name, lat);
    end
    if (checkVal) begin
      nChecks++;
      if (bus4.out_value !== expVal) begin
        nFails++; $display("[TB] FAIL %s_value: got %h expected %h", name, bus4.out_value, expVal);
      end
    end
    nChecks++;
    if (bus4.out_err !== expErr) begin
      nFails++; $display("[TB] FAIL %s_err: got %b expected %b", name, bus4.out_err, expErr);
    end
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    nChecks++;
    if (bus4.out_valid !== 1'b0 || bus4.in_ready !== 1'b1) begin
      nFails++;
      $display("[TB] FAIL %s_release: got valid=%b ready=%b expected valid=0 ready=1",
               name, bus4.out_valid, bus4.in_ready);
    end
  endtask

  task automatic conv2(input logic [15:0] vec, input logic [8:0] expVal, input logic expErr,
                       input logic checkVal, input string name);
    int lat;
    @(negedge clk);
    bus2.in_digits = vec;
    bus2.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.in_valid  = 1'b0;
    bus2.in_digits = '0;
    lat = 0;
    while (bus2.out_valid !== 1'b1 && lat < 30) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    nChecks++;
    if (lat != 8) begin
      nFails++; $display("[TB] FAIL %s_latency: got %0d expected 8", name, lat);
    end
    if (checkVal) begin
      nChecks++;
      if (bus2.out_value !== expVal) begin
        nFails++; $display("[TB] FAIL %s_value: got %h expected %h", name, bus2.out_value, expVal);
      end
    end
    nChecks++;
    if (bus2.out_err !== expErr) begin
      nFails++; $display("[TB] FAIL %s_err: got %b expected %b", name, bus2.out_err, expErr);
    end
    bus2.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus2.out_ready = 1'b0;
    nChecks++;
    if (bus2.out_valid !== 1'b0) begin
      nFails++; $display("[TB] FAIL %s_release: got %b expected 0", name, bus2.out_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nChecks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.out_value !== 9'h000 || bus4.out_err !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset4: got ready=%b valid=%b value=%h err=%b expected 1 0 000 0",
               bus4.in_ready, bus4.out_valid, bus4.out_value, bus4.out_err);
    end
    nChecks++;
    if (bus2.in_ready !== 1'b1 || bus2.out_valid !== 1'b0 || bus2.out_value !== 9'h000) begin
      nFails++;
      $display("[TB] FAIL reset2: got ready=%b valid=%b value=%h expected 1 0 000",
               bus2.in_ready, bus2.out_valid, bus2.out_value);
    end
    rst_n = 1'b1;
    @(negedge clk);
    nChecks++;
    if (bus4.in_ready !== 1'b1) begin
      nFails++; $display("[TB] FAIL reset_release_ready: got %b expected 1", bus4.in_ready);
    end
  endtask

  task automatic test_radix4();
    conv4(pack4(1, -1, 0, 2),   9'h032, 1'b0, 1'b1, "r4_mixed");
    conv4(pack4(-3, -3, -3, -3), 9'h101, 1'b0, 1'b1, "r4_allneg");
    conv4(pack4(3, 3, 3, 3),     9'h0FF, 1'b0, 1'b1, "r4_allpos");
    conv4(pack4(0, 0, 0, 0),     9'h000, 1'b0, 1'b1, "r4_zero");
  endtask

  task automatic test_radix2();
    conv2(pack2(1, -1, 1, -1, 1, -1, 1, -1), 9'h055, 1'b0, 1'b1, "r2_alt");
    conv2(pack2(-1, 0, 0, 0, 0, 0, 0, 1),    9'h181, 1'b0, 1'b1, "r2_negmsd");
    conv2(pack2(0, 0, -2, 0, 0, 0, 0, 0),    9'h000, 1'b1, 1'b0, "r2_illegal");
    conv2(pack2(0, 0, 0, 0, 0, 1, 1, 0),     9'h006, 1'b0, 1'b1, "r2_after_err");
  endtask

  task automatic test_error();
    conv4(pack4(0, -4, 0, 0), 9'h000, 1'b1, 1'b0, "r4_illegal");
    conv4(pack4(0, 0, 1, 1),  9'h005, 1'b0, 1'b1, "r4_after_err");
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    bus4.in_digits = pack4(1, -1, 0, 2);
    bus4.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_digits = pack4(0, 0, 3, -1);
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    nChecks++;
    if (lat != 4) begin
      nFails++; $display("[TB] FAIL bp_latency: got %0d expected 4", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      nChecks++;
      if (bus4.out_value !== 9'h032 || bus4.out_valid !== 1'b1 || bus4.in_ready !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL bp_hold%0d: got value=%h valid=%b ready=%b expected 032 1 0",
                 i, bus4.out_value, bus4.out_valid, bus4.in_ready);
      end
    end
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    nChecks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.out_value !== 9'h032) begin
      nFails++;
      $display("[TB] FAIL bp_handshake: got ready=%b valid=%b value=%h expected 1 0 032",
               bus4.in_ready, bus4.out_valid, bus4.out_value);
    end
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    nChecks++;
    if (bus4.in_ready !== 1'b0) begin
      nFails++; $display("[TB] FAIL bp_accept: got ready=%b expected 0", bus4.in_ready);
    end
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    nChecks++;
    if (lat != 4 || bus4.out_value !== 9'h00B) begin
      nFails++; $display("[TB] FAIL bp_second: got lat=%0d value=%h expected 4 00B", lat, bus4.out_value);
    end
    bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  // With out_ready and in_valid held high, the next result appears NDIG+1 edges after the output handshake.
  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    bus4.out_ready = 1'b1;
    bus4.in_digits = pack4(3, 3, 3, 3);
    bus4.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_digits = pack4(-3, -3, -3, -3);
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    nChecks++;
    if (lat != 4 || bus4.out_value !== 9'h0FF) begin
      nFails++; $display("[TB] FAIL b2b_first: got lat=%0d value=%h expected 4 0FF", lat, bus4.out_value);
    end
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (bus4.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); @(negedge clk); lat++;
      bus4.in_valid = 1'b0;
    end
    nChecks++;
    if (lat != 5) begin
      nFails++; $display("[TB] FAIL b2b_interval: got %0d expected 5", lat);
    end
    nChecks++;
    if (bus4.out_value !== 9'h101) begin
      nFails++; $display("[TB] FAIL b2b_second: got %h expected 101", bus4.out_value);
    end
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int spurious;
    @(negedge clk);
    bus4.in_digits = pack4(2, -3, 1, 1);
    bus4.in_valid  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    nChecks++;
    if (bus4.in_ready !== 1'b0) begin
      nFails++; $display("[TB] FAIL midreset_busy: got %b expected 0", bus4.in_ready);
    end
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || bus4.out_value !== 9'h000) begin
      nFails++;
      $display("[TB] FAIL midreset_clear: got ready=%b valid=%b value=%h expected 1 0 000",
               bus4.in_ready, bus4.out_valid, bus4.out_value);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus4.out_valid !== 1'b0) spurious++;
    end
    nChecks++;
    if (spurious != 0) begin
      nFails++; $display("[TB] FAIL midreset_spurious: got %0d valid cycles expected 0", spurious);
    end
    conv4(pack4(2, -3, 1, 1), 9'h055, 1'b0, 1'b1, "post_reset");
  endtask

  initial begin
    clk            = 1'b0;
    rst_n          = 1'b0;
    nChecks        = 0;
    nFails         = 0;
    bus4.in_digits = '0;
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b0;
    bus2.in_digits = '0;
    bus2.in_valid  = 1'b0;
    bus2.out_ready = 1'b0;
    #12;
    test_reset();
    test_radix4();
    test_radix2();
    test_error();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
